// File: rtl/lfsr_prbs_if.sv
// Signal bundle for lfsr_prbs_engine: generator/checker controls in, LFSR state and
// checker status out.
interface lfsr_prbs_if #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned ERR_WIDTH = 16
);
   logic                 mode;
   logic                 en;
   logic                 load;
   logic [WIDTH-1:0]     seed;
   logic                 din;
   logic                 din_valid;
   logic                 clr_err;
   logic [WIDTH-1:0]     q;
   logic                 dout;
   logic                 locked;
   logic                 err_pulse;
   logic [ERR_WIDTH-1:0] err_count;
   logic                 lockup_fix;

   modport master (
      output mode, en, load, seed, din, din_valid, clr_err,
      input  q, dout, locked, err_pulse, err_count, lockup_fix
   );

   modport slave (
      input  mode, en, load, seed, din, din_valid, clr_err,
      output q, dout, locked, err_pulse, err_count, lockup_fix
   );
endinterface

// File: rtl/lfsr_prbs_engine.sv
// Fibonacci XNOR LFSR acting as PRBS generator (mode=0) or self-synchronising
// PRBS checker with lock/loss tracking and a saturating error counter (mode=1).
module lfsr_prbs_engine #(
   parameter int unsigned    WIDTH      = 16,
   parameter logic [WIDTH-1:0] TAPS     = 16'hD008,
   parameter int unsigned    LOCK_COUNT = 8,
   parameter int unsigned    LOSS_COUNT = 4,
   parameter int unsigned    ERR_WIDTH  = 16
) (
   input  logic         clk,
   input  logic         reset,
   lfsr_prbs_if.slave   bus
);

   localparam int unsigned FillW = $clog2(WIDTH + 1);
   localparam int unsigned LockW = $clog2(LOCK_COUNT + 1);
   localparam int unsigned LossW = $clog2(LOSS_COUNT + 1);

   localparam logic [0:0] StSearch = 1'b0;
   localparam logic [0:0] StLocked = 1'b1;

   logic [WIDTH-1:0]     q_d, q_q;
   logic [0:0]           state_d, state_q;
   logic [FillW-1:0]     fill_cnt_d, fill_cnt_q;
   logic [LockW-1:0]     match_cnt_d, match_cnt_q;
   logic [LossW-1:0]     miss_cnt_d, miss_cnt_q;
   logic [ERR_WIDTH-1:0] err_count_d, err_count_q;
   logic                 err_pulse_d, err_pulse_q;
   logic                 lockup_fix_d, lockup_fix_q;
   logic                 fb;
   logic                 err_hit;

   // XNOR feedback keeps all-zeros legal; all-ones is the stuck state.
   assign fb = ~^(q_q & TAPS);

   always_comb begin
      q_d          = q_q;
      state_d      = state_q;
      fill_cnt_d   = fill_cnt_q;
      match_cnt_d  = match_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      err_pulse_d  = 1'b0;
      lockup_fix_d = 1'b0;
      err_hit      = 1'b0;

      if (!bus.mode) begin
         state_d     = StSearch;
         fill_cnt_d  = '0;
         match_cnt_d = '0;
         miss_cnt_d  = '0;
         if (bus.load) begin
            if (&bus.seed) begin
               q_d          = '0;
               lockup_fix_d = 1'b1;
            end else begin
               q_d = bus.seed;
            end
         end else if (bus.en) begin
            q_d = {q_q[WIDTH-2:0], fb};
         end
      end else if (bus.din_valid) begin
         case (state_q)
            StSearch: begin
               q_d = {q_q[WIDTH-2:0], bus.din};
               if (fill_cnt_q < FillW'(WIDTH)) begin
                  fill_cnt_d = fill_cnt_q + FillW'(1);
               end else if (bus.din == fb) begin
                  if (match_cnt_q == LockW'(LOCK_COUNT - 1)) begin
                     state_d     = StLocked;
                     match_cnt_d = '0;
                     miss_cnt_d  = '0;
                  end else begin
                     match_cnt_d = match_cnt_q + LockW'(1);
                  end
               end else begin
                  match_cnt_d = '0;
               end
            end
            default: begin
               // Locked: free-run on internal feedback, din only scored.
               q_d = {q_q[WIDTH-2:0], fb};
               if (bus.din == fb) begin
                  miss_cnt_d = '0;
               end else begin
                  err_hit     = 1'b1;
                  err_pulse_d = 1'b1;
                  if (miss_cnt_q == LossW'(LOSS_COUNT - 1)) begin
                     state_d     = StSearch;
                     fill_cnt_d  = '0;
                     match_cnt_d = '0;
                     miss_cnt_d  = '0;
                  end else begin
                     miss_cnt_d = miss_cnt_q + LossW'(1);
                  end
               end
            end
         endcase
      end

      err_count_d = err_count_q;
      if (bus.clr_err) begin
         err_count_d = '0;
      end else if (err_hit && !(&err_count_q)) begin
         err_count_d = err_count_q + ERR_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q          <= '0;
         state_q      <= StSearch;
         fill_cnt_q   <= '0;
         match_cnt_q  <= '0;
         miss_cnt_q   <= '0;
         err_count_q  <= '0;
         err_pulse_q  <= 1'b0;
         lockup_fix_q <= 1'b0;
      end else begin
         q_q          <= q_d;
         state_q      <= state_d;
         fill_cnt_q   <= fill_cnt_d;
         match_cnt_q  <= match_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         err_count_q  <= err_count_d;
         err_pulse_q  <= err_pulse_d;
         lockup_fix_q <= lockup_fix_d;
      end
   end

   assign bus.q          = q_q;
   assign bus.dout       = q_q[WIDTH-1];
   assign bus.locked     = (state_q == StLocked);
   assign bus.err_pulse  = err_pulse_q;
   assign bus.err_count  = err_count_q;
   assign bus.lockup_fix = lockup_fix_q;

endmodule

// File: doc/lfsr_prbs_engine.md
# lfsr_prbs_engine

Parametrised Fibonacci LFSR engine with two modes: PRBS generator and self-synchronising PRBS checker. It supersedes the fixed 16-bit LFSR with:
- configurable width and tap mask;
- seed load;
- lock-up protection;
- a checker with lock/loss state machine and saturating error counter.

It sits in the reference-design test path: the generator drives link test patterns and the checker validates the returned bit stream.

## Interface
- WIDTH, 16, LFSR length in bits (≥3).
- TAPS, 16'hD008, tap mask; bit i set means q[i] feeds back (default taps 15, 14, 12, 3).
- LOCK_COUNT, 8, consecutive matches required to declare lock.
- LOSS_COUNT, 4, consecutive mismatches in LOCKED that drop lock.
- ERR_WIDTH, 16, error counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- mode  in  1  0 = generate, 1 = check.
- en  in  1  generator advance enable.
- load  in  1  generator seed load (ignored when mode=1).
- seed  in  WIDTH  seed value.
- din  in  1  checker serial input bit.
- din_valid  in  1  checker input qualifier.
- clr_err  in  1  synchronous clear of err_count.
- q  out  WIDTH  LFSR state register.
- dout  out  1  serial output, equal to q[WIDTH-1].
- locked  out  1  checker in LOCKED state.
- err_pulse  out  1  one-cycle pulse per checker bit error.
- err_count  out  ERR_WIDTH  saturating error count.
- lockup_fix  out  1  one-cycle pulse when an all-ones seed was replaced.

## Operation
- Feedback: fb = XNOR-reduce(q & TAPS). Shift: q ← {q[WIDTH-2:0], fb}. The all-ones state is the lock-up state.
- Reset values: q=0, locked=0, err_pulse=0, err_count=0, lockup_fix=0, state=SEARCH, fill_cnt=0, match_cnt=0, miss_cnt=0.
- Generate mode (mode=0), per clock:
  - load=1 and seed≠all-ones: q ← seed.
  - load=1 and seed=all-ones: q ← 0 and lockup_fix=1.
  - load=0 and en=1: q shifts with fb.
  - Otherwise q holds.
  - load has priority over en.
  - Checker state is forced to SEARCH with its counters at 0.
- Check mode (mode=1): the FSM acts only on cycles with din_valid=1; all state holds otherwise. The predicted bit is fb of the current q.
  - SEARCH, fill phase (fill_cnt < WIDTH): q ← {q[WIDTH-2:0], din}; fill_cnt++. No comparison.
  - SEARCH, compare phase (fill_cnt = WIDTH): q ← {q[WIDTH-2:0], din}.
    - If din = fb, match_cnt++. When this makes match_cnt = LOCK_COUNT, go to LOCKED, clear match_cnt and miss_cnt.
    - If din ≠ fb, match_cnt ← 0.
  - LOCKED: q advances with the internal fb (din is not shifted in).
    - If din = fb, miss_cnt ← 0.
    - If din ≠ fb: err_pulse=1, err_count increments and saturates at all-ones, miss_cnt++. When this makes miss_cnt = LOSS_COUNT, go to SEARCH with fill_cnt=0 and match_cnt=0.
  - No err_pulse is ever produced in SEARCH.
- A 0→1 transition of mode enters SEARCH with fill_cnt=0. q is not cleared but is overwritten by the fill.
- clr_err=1 zeroes err_count in that cycle. A simultaneous error does not count; clr_err wins.
- err_count and the lockup_fix pulse are retained across mode changes. Only reset and clr_err clear err_count.
- Reset asserted mid-operation returns every register to its reset value immediately, independent of clk.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Generator: q reflects load or advance one clock after the sampling edge. dout = q[WIDTH-1] in the same cycle.
- Checker lock latency: locked rises at the edge sampling the (WIDTH+LOCK_COUNT)-th valid error-free bit after entering SEARCH (24 for defaults).
- err_pulse is high for exactly the one cycle following the edge that sampled the erroneous bit. Back-to-back errors give consecutive pulses.
- Loss latency: locked falls at the edge sampling the LOSS_COUNT-th consecutive mismatch. That mismatch is still counted.
- Throughput: one bit per clock when en=1 or din_valid=1.

## Test plan
- Reset, mode=0, en=1, load=0 → q sequence 0x0001, 0x0003, 0x0007, 0x000F, 0x001E on successive clocks.
- Generator coverage: load seed 0xACE1, then run 65535 clocks with en=1 → q returns to 0xACE1 at exactly clock 65535, never before, and never equals 0xFFFF.
- Lock-up protection: load=1 with seed=0xFFFF → q=0x0000 and lockup_fix high for exactly one cycle. Same cycle with load=1, en=1, seed=0x1234 → q=0x1234 (load wins).
- Checker acquire: loop a second instance's dout into din with din_valid=1 → locked=1 after exactly 24 valid bits, err_count=0. Gaps inserted in din_valid stretch acquisition by exactly the gap length.
- Single error: invert one bit while locked → one err_pulse, err_count=1, locked stays 1. Then assert clr_err together with a second inverted bit → err_count=0.
- Loss and saturation:
  - 4 consecutive inverted bits → locked=0 after the 4th, err_count=4, re-lock after 24 further clean bits.
  - With ERR_WIDTH=4 and a continuous inverted stream, err_count sticks at 15.
  - Reset asserted mid-stream clears all outputs asynchronously.
